// File: rtl/pwm_audio_pkg.sv
// Shared constants and helpers for the multi-channel PWM/PDM audio output stage.
package pwm_audio_pkg;

  localparam logic PWM_MODE_EDGE = 1'b0;
  localparam logic PWM_MODE_PDM  = 1'b1;

  // Full-scale sample value; it is also the number of ticks in one output period.
  function automatic int unsigned pwm_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/pwm_audio_chan.sv
// One output channel. It holds the edge-aligned PWM comparator, the first-order
// sigma-delta accumulator and the registered output pin.
module pwm_audio_chan #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] count,
  input  logic             tick,
  input  logic [WIDTH-1:0] active,
  input  logic             mode_q,
  input  logic             acc_clr,
  output logic             pwm
);
  import pwm_audio_pkg::*;

  localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(pwm_max(WIDTH));

  logic [WIDTH-1:0] acc;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             pdm_bit;

  // The sigma-delta step carries one extra bit so that acc + sample cannot overflow.
  always_comb begin
    sum     = {1'b0, acc} + {1'b0, active};
    diff    = sum - MAX_EXT;
    pdm_bit = (sum >= MAX_EXT);
  end

  // Accumulator update and output flop. In PDM mode the output bit is held between ticks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      pwm <= 1'b0;
    end else begin
      if (acc_clr) begin
        acc <= '0;
      end else if (mode_q == PWM_MODE_PDM && tick) begin
        acc <= pdm_bit ? diff[WIDTH-1:0] : sum[WIDTH-1:0];
      end
      if (mode_q == PWM_MODE_EDGE) begin
        pwm <= (count < active);
      end else if (tick) begin
        pwm <= pdm_bit;
      end
    end
  end

endmodule

// File: rtl/pwm_audio_mc.sv
// Multi-channel PWM/PDM audio output stage. This module contains the prescaler,
// the period counter, the sample handshake, the hold/active double buffer and
// the underrun flag. It drives one pwm_audio_chan per channel.
module pwm_audio_mc #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2,
  parameter int PRESCALE = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] sample_in,
  input  logic                      sample_valid,
  output logic                      sample_ready,
  input  logic                      mode,
  input  logic                      underrun_clr,
  output logic [CHANNELS-1:0]       pwm,
  output logic                      period_start,
  output logic                      underrun
);
  import pwm_audio_pkg::*;

  localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(pwm_max(WIDTH) - 1);

  logic [PRE_W-1:0]          pre;
  logic [WIDTH-1:0]          count;
  logic                      tick;
  logic                      wrap;
  logic                      accept;
  logic                      hold_full;
  logic                      mode_q;
  logic                      acc_clr;
  logic [CHANNELS*WIDTH-1:0] hold;
  logic [CHANNELS*WIDTH-1:0] active;

  // Timing strobes and handshake, all derived directly from the registered state.
  always_comb begin
    tick         = (pre == PRE_LAST);
    wrap         = tick && (count == CNT_LAST);
    sample_ready = !hold_full;
    accept       = sample_valid && !hold_full;
    acc_clr      = wrap && (mode != mode_q);
  end

  // Prescaler and period counter. The counter steps once per tick and wraps after MAX-1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre   <= '0;
      count <= '0;
    end else begin
      pre <= tick ? '0 : pre + PRE_W'(1);
      if (tick) begin
        count <= wrap ? '0 : count + WIDTH'(1);
      end
    end
  end

  // Double buffer. An accept can only happen while hold is empty, so it never
  // collides with the hold-to-active transfer. The output mode is latched at the boundary.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold      <= '0;
      hold_full <= 1'b0;
      active    <= '0;
      mode_q    <= PWM_MODE_EDGE;
    end else begin
      if (accept) begin
        hold      <= sample_in;
        hold_full <= 1'b1;
      end else if (wrap && hold_full) begin
        active    <= hold;
        hold_full <= 1'b0;
      end
      if (wrap) begin
        mode_q <= mode;
      end
    end
  end

  // Sticky underrun flag. If a boundary with an empty hold buffer coincides with a clear, the flag is set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      underrun <= 1'b0;
    end else if (wrap && !hold_full) begin
      underrun <= 1'b1;
    end else if (underrun_clr) begin
      underrun <= 1'b0;
    end
  end

  // The period_start pulse is high on the first clock at which count reads 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period_start <= 1'b0;
    end else begin
      period_start <= wrap;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    pwm_audio_chan #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .count  (count),
      .tick   (tick),
      .active (active[i*WIDTH +: WIDTH]),
      .mode_q (mode_q),
      .acc_clr(acc_clr),
      .pwm    (pwm[i])
    );
  end

endmodule

// File: tb/tb_pwm_audio_mc.sv
// Self-checking bench for pwm_audio_mc. Instance dut uses WIDTH=8, CHANNELS=2, PRESCALE=1.
// Instance dut_b uses WIDTH=4, CHANNELS=2, PRESCALE=4. The expected high-count per period
// is queued when a frame is offered and popped when that period has been measured.
module tb_pwm_audio_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic        mode;
  logic        underrun_clr;
  logic [1:0]  pwm;
  logic        period_start;
  logic        underrun;

  logic        rst_n_b;
  logic [7:0]  sample_in_b;
  logic        sample_valid_b;
  logic        sample_ready_b;
  logic [1:0]  pwm_b;
  logic        period_start_b;
  logic        underrun_b;

  int checks = 0;
  int errors = 0;
  int hi0, hi1, ps_seen;
  int hi0_b, hi1_b, ps_seen_b;
  logic [15:0] exp_q[$];
  logic [15:0] exp_b[$];
  logic [15:0] exp_w;

  pwm_audio_mc #(.WIDTH(8), .CHANNELS(2), .PRESCALE(1)) dut (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .mode(mode), .underrun_clr(underrun_clr),
    .pwm(pwm), .period_start(period_start), .underrun(underrun)
  );

  pwm_audio_mc #(.WIDTH(4), .CHANNELS(2), .PRESCALE(4)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .sample_in(sample_in_b), .sample_valid(sample_valid_b),
    .sample_ready(sample_ready_b), .mode(1'b0), .underrun_clr(1'b0),
    .pwm(pwm_b), .period_start(period_start_b), .underrun(underrun_b)
  );

  // Step n clocks of dut and accumulate the high count of each channel and the period_start pulses.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (pwm[0] === 1'b1) hi0++;
      if (pwm[1] === 1'b1) hi1++;
      if (period_start === 1'b1) ps_seen++;
    end
  endtask

  task automatic clear_counts();
    hi0 = 0; hi1 = 0; ps_seen = 0;
  endtask

  // Step n clocks of dut_b and accumulate its channel high counts and period_start pulses.
  task automatic step_b(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (pwm_b[0] === 1'b1) hi0_b++;
      if (pwm_b[1] === 1'b1) hi1_b++;
      if (period_start_b === 1'b1) ps_seen_b++;
    end
  endtask

  task automatic clear_counts_b();
    hi0_b = 0; hi1_b = 0; ps_seen_b = 0;
  endtask

  // Reset values, ready after release, and the first empty period ends in underrun.
  task automatic test_reset();
    int n;
    rst_n = 1'b0; sample_valid = 1'b0; sample_in = '0; mode = 1'b0; underrun_clr = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (pwm !== 2'b00) begin errors++; $display("[TB] FAIL reset_pwm: got %b expected 00", pwm); end
    checks++; if (period_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_period_start: got %b expected 0", period_start); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_underrun: got %b expected 0", underrun); end
    rst_n = 1'b1;
    checks++; if (sample_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", sample_ready); end
    clear_counts();
    n = 0;
    while (n < 400) begin
      step(1);
      n++;
      if (period_start === 1'b1) break;
    end
    checks++; if (n != 255) begin errors++; $display("[TB] FAIL first_period_len: got %0d expected 255", n); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("[TB] FAIL first_underrun: got %b expected 1", underrun); end
    checks++; if (hi0 + hi1 != 0) begin errors++; $display("[TB] FAIL first_period_silent: got %0d highs expected 0", hi0 + hi1); end
  endtask

  // The PWM duty of two consecutive frames; each change takes effect at period_start.
  task automatic test_pwm_duty();
    logic [15:0] fr;
    exp_q.push_back(16'h0000);
    for (int i = 0; i < 2; i++) begin
      fr = (i == 0) ? 16'hFF00 : 16'h8001;
      sample_in = fr; sample_valid = 1'b1;
      exp_q.push_back(fr);
      clear_counts();
      step(1);
      checks++; if (sample_ready !== 1'b0) begin errors++; $display("[TB] FAIL duty_accept%0d: ready %b expected 0", i, sample_ready); end
      sample_valid = 1'b0;
      step(254);
      checks++; if (period_start !== 1'b1 || ps_seen != 1) begin errors++; $display("[TB] FAIL duty_align%0d: ps %b seen %0d expected 1/1", i, period_start, ps_seen); end
      exp_w = exp_q.pop_front();
      checks++; if (hi0 != int'(exp_w[7:0])) begin errors++; $display("[TB] FAIL duty%0d_ch0: got %0d expected %0d", i, hi0, exp_w[7:0]); end
      checks++; if (hi1 != int'(exp_w[15:8])) begin errors++; $display("[TB] FAIL duty%0d_ch1: got %0d expected %0d", i, hi1, exp_w[15:8]); end
    end
  endtask

  // A frame accepted mid-period blocks a second frame until the next boundary.
  task automatic test_double_buffer();
    int busy_bad;
    clear_counts();
    step(100);
    sample_in = 16'h140A; sample_valid = 1'b1;
    exp_q.push_back(16'h140A);
    step(1);
    checks++; if (sample_ready !== 1'b0) begin errors++; $display("[TB] FAIL db_first_accept: ready %b expected 0", sample_ready); end
    sample_in = 16'h281E;
    busy_bad = 0;
    for (int k = 0; k < 153; k++) begin
      step(1);
      if (sample_ready !== 1'b0) busy_bad++;
    end
    step(1);
    checks++; if (busy_bad != 0) begin errors++; $display("[TB] FAIL db_ready_held_low: got %0d ready clocks expected 0", busy_bad); end
    checks++; if (sample_ready !== 1'b1 || period_start !== 1'b1) begin errors++; $display("[TB] FAIL db_wrap_ready: ready %b ps %b expected 1/1", sample_ready, period_start); end
    exp_w = exp_q.pop_front();
    checks++; if (hi0 != int'(exp_w[7:0]) || hi1 != int'(exp_w[15:8])) begin errors++; $display("[TB] FAIL db_unchanged_period: got %0d/%0d expected %0d/%0d", hi0, hi1, exp_w[7:0], exp_w[15:8]); end
    exp_q.push_back(16'h281E);
    clear_counts();
    step(1);
    checks++; if (sample_ready !== 1'b0) begin errors++; $display("[TB] FAIL db_second_accept: ready %b expected 0", sample_ready); end
    sample_valid = 1'b0;
    step(254);
    exp_w = exp_q.pop_front();
    checks++; if (hi0 != int'(exp_w[7:0]) || hi1 != int'(exp_w[15:8])) begin errors++; $display("[TB] FAIL db_new_period: got %0d/%0d expected %0d/%0d", hi0, hi1, exp_w[7:0], exp_w[15:8]); end
  endtask

  // Clearing underrun, set winning over clear at a boundary, and repetition of the previous duty.
  task automatic test_underrun();
    clear_counts();
    underrun_clr = 1'b1;
    step(1);
    underrun_clr = 1'b0;
    checks++; if (underrun !== 1'b0) begin errors++; $display("[TB] FAIL ur_clear: got %b expected 0", underrun); end
    exp_q.push_back(16'h281E);
    step(253);
    checks++; if (underrun !== 1'b0) begin errors++; $display("[TB] FAIL ur_stays_clear: got %b expected 0", underrun); end
    underrun_clr = 1'b1;
    step(1);
    underrun_clr = 1'b0;
    checks++; if (period_start !== 1'b1 || underrun !== 1'b1) begin errors++; $display("[TB] FAIL ur_set_wins: ps %b underrun %b expected 1/1", period_start, underrun); end
    exp_w = exp_q.pop_front();
    checks++; if (hi0 != int'(exp_w[7:0]) || hi1 != int'(exp_w[15:8])) begin errors++; $display("[TB] FAIL ur_period: got %0d/%0d expected %0d/%0d", hi0, hi1, exp_w[7:0], exp_w[15:8]); end
    mode = 1'b1;
    sample_in = 16'hFF55; sample_valid = 1'b1;
    exp_q.push_back(16'hFF55);
    clear_counts();
    step(1);
    sample_valid = 1'b0;
    step(254);
    exp_w = exp_q.pop_front();
    checks++; if (hi0 != int'(exp_w[7:0]) || hi1 != int'(exp_w[15:8])) begin errors++; $display("[TB] FAIL ur_repeat_duty: got %0d/%0d expected %0d/%0d", hi0, hi1, exp_w[7:0], exp_w[15:8]); end
  endtask

  // PDM: sample 85 gives one 1 every third tick, and sample 255 gives a constant 1.
  task automatic test_pdm();
    int pat_bad, const_bad;
    pat_bad = 0; const_bad = 0;
    clear_counts();
    for (int k = 1; k <= 255; k++) begin
      step(1);
      if (pwm[0] !== ((k % 3) == 0)) pat_bad++;
      if (pwm[1] !== 1'b1) const_bad++;
    end
    checks++; if (pat_bad != 0) begin errors++; $display("[TB] FAIL pdm_pattern: got %0d bad ticks expected 0", pat_bad); end
    checks++; if (const_bad != 0) begin errors++; $display("[TB] FAIL pdm_full_scale: got %0d low ticks expected 0", const_bad); end
    exp_w = exp_q.pop_front();
    checks++; if (hi0 != int'(exp_w[7:0]) || hi1 != int'(exp_w[15:8])) begin errors++; $display("[TB] FAIL pdm_density: got %0d/%0d expected %0d/%0d", hi0, hi1, exp_w[7:0], exp_w[15:8]); end
  endtask

  // PRESCALE=4, WIDTH=4: 60-clock periods, 20 high clocks for sample 5, and a reset mid-period.
  task automatic test_prescale();
    int n;
    checks++; if (pwm_b !== 2'b00) begin errors++; $display("[TB] FAIL pre_reset_state: got %b expected 00", pwm_b); end
    rst_n_b = 1'b1;
    sample_in_b = 8'hF5; sample_valid_b = 1'b1;
    exp_b.push_back(16'h0000);
    exp_b.push_back(16'd60 << 8 | 16'd20);
    clear_counts_b();
    step_b(1);
    sample_valid_b = 1'b0;
    n = 1;
    while (n < 200 && period_start_b !== 1'b1) begin
      step_b(1);
      n++;
    end
    checks++; if (n != 60) begin errors++; $display("[TB] FAIL pre_first_period: got %0d clocks expected 60", n); end
    exp_w = exp_b.pop_front();
    checks++; if (hi0_b != int'(exp_w[7:0]) || hi1_b != int'(exp_w[15:8])) begin errors++; $display("[TB] FAIL pre_first_silent: got %0d/%0d expected %0d/%0d", hi0_b, hi1_b, exp_w[7:0], exp_w[15:8]); end
    clear_counts_b();
    step_b(60);
    checks++; if (period_start_b !== 1'b1 || ps_seen_b != 1) begin errors++; $display("[TB] FAIL pre_interval: ps %b seen %0d expected 1/1", period_start_b, ps_seen_b); end
    exp_w = exp_b.pop_front();
    checks++; if (hi0_b != int'(exp_w[7:0]) || hi1_b != int'(exp_w[15:8])) begin errors++; $display("[TB] FAIL pre_duty: got %0d/%0d expected %0d/%0d", hi0_b, hi1_b, exp_w[7:0], exp_w[15:8]); end
    sample_in_b = 8'hFF; sample_valid_b = 1'b1;
    step_b(1);
    sample_valid_b = 1'b0;
    step_b(29);
    rst_n_b = 1'b0;
    step_b(1);
    checks++; if (dut_b.count !== 4'd0) begin errors++; $display("[TB] FAIL pre_reset_count: got %0d expected 0", dut_b.count); end
    checks++; if (pwm_b !== 2'b00) begin errors++; $display("[TB] FAIL pre_reset_pwm: got %b expected 00", pwm_b); end
    checks++; if (sample_ready_b !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_ready: got %b expected 1", sample_ready_b); end
    rst_n_b = 1'b1;
    exp_b.push_back(16'h0000);
    exp_b.push_back(16'h0000);
    clear_counts_b();
    n = 0;
    while (n < 200) begin
      step_b(1);
      n++;
      if (period_start_b === 1'b1) break;
    end
    checks++; if (n != 60) begin errors++; $display("[TB] FAIL pre_restart_period: got %0d clocks expected 60", n); end
    exp_w = exp_b.pop_front();
    checks++; if (hi0_b != int'(exp_w[7:0]) || hi1_b != int'(exp_w[15:8])) begin errors++; $display("[TB] FAIL pre_restart_silent: got %0d/%0d expected %0d/%0d", hi0_b, hi1_b, exp_w[7:0], exp_w[15:8]); end
    clear_counts_b();
    step_b(60);
    exp_w = exp_b.pop_front();
    checks++; if (hi0_b != int'(exp_w[7:0]) || hi1_b != int'(exp_w[15:8])) begin errors++; $display("[TB] FAIL pre_hold_discarded: got %0d/%0d expected %0d/%0d", hi0_b, hi1_b, exp_w[7:0], exp_w[15:8]); end
    checks++; if (underrun_b !== 1'b1) begin errors++; $display("[TB] FAIL pre_underrun: got %b expected 1", underrun_b); end
  endtask

  // Run the scenarios in order. dut_b is held in reset until its own test starts.
  initial begin
    rst_n_b = 1'b0; sample_in_b = '0; sample_valid_b = 1'b0;
    test_reset();
    test_pwm_duty();
    test_double_buffer();
    test_underrun();
    test_pdm();
    test_prescale();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
